rom_ecc_reader: RTL and testbench

- Read controller for the Hamming-protected ROM path.
- Accepts a read request, addresses the ROM and routes the raw 21-bit codeword to the adjacent combinational Hamming(21,16) decoder.
- Registers the decoded 16-bit word and its error flag behind a valid/ready response interface.
- Keeps a saturating count of corrected-error events for the status block.

---
 rtl/rom_ecc_reader.sv | 176 +++++++++++++++++
 tb/tb_rom_ecc_reader.sv | 495 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_ecc_reader.sv
// -----------------------------------------------------------------------------
// rom_ecc_reader
//   Read controller for the Hamming(21,16)-protected ROM path. It accepts one
//   read request at a time and strobes the ROM. The raw codeword is routed to
//   the external combinational decoder. The decoded word, its error flag and
//   the request address are registered behind a valid/ready response port. A
//   saturating counter records corrected-error events.
//
// Parameters
//   ADDR_W  ROM word-address width
//   RD_LAT  ROM read latency, rom_en_o cycle to rom_data_i valid (1..4)
//   CNT_W   corrected-error counter width
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_valid_i/req_ready_o/req_addr_i   read request handshake + address
//   rom_en_o/rom_addr_o/rom_data_i       ROM strobe, address, raw codeword
//   dec_cw_o/dec_data_i/dec_err_i        decoder codeword out, result in
//   rsp_valid_o/rsp_ready_i              response handshake
//   rsp_data_o/rsp_err_o/rsp_addr_o      registered response fields
//   err_cnt_clr_i/err_cnt_o              counter clear, saturating count
//
// Optional build macro ROM_ECC_ERR_LOG_EN adds:
//   last_err_addr_o   address of the most recent corrected-error read
//   last_err_vld_o    set on an error event, cleared by err_cnt_clr_i
// -----------------------------------------------------------------------------
module rom_ecc_reader #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    output logic              rom_en_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [20:0]       rom_data_i,
    output logic [20:0]       dec_cw_o,
    input  logic [15:0]       dec_data_i,
    input  logic              dec_err_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [15:0]       rsp_data_o,
    output logic              rsp_err_o,
    output logic [ADDR_W-1:0] rsp_addr_o,
    input  logic              err_cnt_clr_i,
`ifdef ROM_ECC_ERR_LOG_EN
    output logic [ADDR_W-1:0] last_err_addr_o,
    output logic              last_err_vld_o,
`endif
    output logic [CNT_W-1:0]  err_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t            r_state;
    logic              r_req_ready;
    logic              r_rom_en;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [1:0]        r_wait_cnt;   // RD_LAT <= 4, so 2 bits cover RD_LAT-1
    logic              r_rsp_valid;
    logic [15:0]       r_rsp_data;
    logic              r_rsp_err;
    logic [ADDR_W-1:0] r_rsp_addr;
    logic [CNT_W-1:0]  r_err_cnt;
`ifdef ROM_ECC_ERR_LOG_EN
    logic [ADDR_W-1:0] r_last_err_addr;
    logic              r_last_err_vld;
`endif

    logic w_capture;
    logic w_err_evt;
    logic w_cnt_sat;

    // Capture happens in the WAIT cycle where the ROM data is valid.
    assign w_capture = (r_state == ST_WAIT) && (r_wait_cnt == '0);
    assign w_err_evt = w_capture && dec_err_i;
    assign w_cnt_sat = &r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_req_ready     <= 1'b1;
            r_rom_en        <= 1'b0;
            r_rom_addr      <= '0;
            r_wait_cnt      <= '0;
            r_rsp_valid     <= 1'b0;
            r_rsp_data      <= '0;
            r_rsp_err       <= 1'b0;
            r_rsp_addr      <= '0;
            r_err_cnt       <= '0;
`ifdef ROM_ECC_ERR_LOG_EN
            r_last_err_addr <= '0;
            r_last_err_vld  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid_i && r_req_ready) begin
                        r_rom_addr  <= req_addr_i;
                        r_rom_en    <= 1'b1;
                        r_req_ready <= 1'b0;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_rom_en   <= 1'b0;
                    r_wait_cnt <= 2'(RD_LAT - 1);
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_rsp_data  <= dec_data_i;
                        r_rsp_err   <= dec_err_i;
                        r_rsp_addr  <= r_rom_addr;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_HOLD;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 2'd1;
                    end
                end
                ST_HOLD: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_req_ready <= 1'b1;
                    r_rom_en    <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase

            // A clear coinciding with an error event keeps that event (count 1).
            if (err_cnt_clr_i) begin
                r_err_cnt <= w_err_evt ? CNT_W'(1) : '0;
            end else if (w_err_evt && !w_cnt_sat) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end

`ifdef ROM_ECC_ERR_LOG_EN
            if (w_err_evt) begin
                r_last_err_addr <= r_rom_addr;
                r_last_err_vld  <= 1'b1;
            end else if (err_cnt_clr_i) begin
                r_last_err_vld  <= 1'b0;
            end
`endif
        end
    end

    assign dec_cw_o    = rom_data_i;
    assign req_ready_o = r_req_ready;
    assign rom_en_o    = r_rom_en;
    assign rom_addr_o  = r_rom_addr;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_data_o  = r_rsp_data;
    assign rsp_err_o   = r_rsp_err;
    assign rsp_addr_o  = r_rsp_addr;
    assign err_cnt_o   = r_err_cnt;
`ifdef ROM_ECC_ERR_LOG_EN
    assign last_err_addr_o = r_last_err_addr;
    assign last_err_vld_o  = r_last_err_vld;
`endif

endmodule

// File: tb/tb_rom_ecc_reader.sv
// -----------------------------------------------------------------------------
// tb_rom_ecc_reader
//   Two instances: index 0 uses RD_LAT=1, CNT_W=16 and index 1 uses RD_LAT=3,
//   CNT_W=4. A ROM model drives each instance. It presents the stored
//   codeword only in the exact cycle it becomes valid and random junk in all
//   other cycles. A stand-in decoder passes codeword bits [15:0] through as
//   data and uses bit [20] as the error flag. Expected responses come from the
//   ROM array and a saturating-count model.
// -----------------------------------------------------------------------------
module tb_rom_ecc_reader;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid [2];
    logic        req_ready [2];
    logic [9:0]  req_addr  [2];
    logic        rom_en    [2];
    logic [9:0]  rom_addr  [2];
    logic [20:0] rom_data  [2];
    logic [20:0] dec_cw    [2];
    logic [15:0] dec_data  [2];
    logic        dec_err   [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [15:0] rsp_data  [2];
    logic        rsp_err   [2];
    logic [9:0]  rsp_addr  [2];
    logic        clr       [2];
    logic [15:0] err_cnt_a;
    logic [3:0]  err_cnt_b;
`ifdef ROM_ECC_ERR_LOG_EN
    logic [9:0]  le_addr [2];
    logic        le_vld  [2];
`endif

    rom_ecc_reader #(.ADDR_W(10), .RD_LAT(LAT_A), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_addr_i(req_addr[0]),
        .rom_en_o(rom_en[0]), .rom_addr_o(rom_addr[0]), .rom_data_i(rom_data[0]),
        .dec_cw_o(dec_cw[0]), .dec_data_i(dec_data[0]), .dec_err_i(dec_err[0]),
        .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_data_o(rsp_data[0]),
        .rsp_err_o(rsp_err[0]), .rsp_addr_o(rsp_addr[0]), .err_cnt_clr_i(clr[0]),
`ifdef ROM_ECC_ERR_LOG_EN
        .last_err_addr_o(le_addr[0]), .last_err_vld_o(le_vld[0]),
`endif
        .err_cnt_o(err_cnt_a)
    );

    rom_ecc_reader #(.ADDR_W(10), .RD_LAT(LAT_B), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_addr_i(req_addr[1]),
        .rom_en_o(rom_en[1]), .rom_addr_o(rom_addr[1]), .rom_data_i(rom_data[1]),
        .dec_cw_o(dec_cw[1]), .dec_data_i(dec_data[1]), .dec_err_i(dec_err[1]),
        .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_data_o(rsp_data[1]),
        .rsp_err_o(rsp_err[1]), .rsp_addr_o(rsp_addr[1]), .err_cnt_clr_i(clr[1]),
`ifdef ROM_ECC_ERR_LOG_EN
        .last_err_addr_o(le_addr[1]), .last_err_vld_o(le_vld[1]),
`endif
        .err_cnt_o(err_cnt_b)
    );

    int checks = 0;
    int failures = 0;
    logic [20:0] mem [1024];
    int exp_cnt [2];

    function automatic int lat_of(input int d);
        return (d == 0) ? LAT_A : LAT_B;
    endfunction

    function automatic int cnt_max(input int d);
        return (d == 0) ? 65535 : 15;
    endfunction

    function automatic int get_cnt(input int d);
        return (d == 0) ? int'(err_cnt_a) : int'(err_cnt_b);
    endfunction

    // ROM model: rk counts cycles since the strobe; data valid when rk == latency.
    int          rk      [2];
    logic [9:0]  raddr_m [2];
    logic [20:0] junk    [2];

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            junk[d] <= 21'($urandom);
            if (!rst_n) begin
                rk[d] <= 0;
            end else if (rom_en[d] === 1'b1) begin
                rk[d]      <= 1;
                raddr_m[d] <= rom_addr[d];
            end else if (rk[d] != 0 && rk[d] < lat_of(d)) begin
                rk[d] <= rk[d] + 1;
            end else begin
                rk[d] <= 0;
            end
        end
    end

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            rom_data[d] = (rk[d] == lat_of(d)) ? mem[raddr_m[d]] : junk[d];
            dec_data[d] = rom_data[d][15:0];
            dec_err[d]  = rom_data[d][20];
        end
    end

    // One full read transaction; reports observations, checks nothing itself.
    task automatic run_read(input int d, input logic [9:0] addr, input int bp,
                            output int lat, output int en_pulses, output bit en_addr_ok,
                            output bit held_ok, output bit done_ok,
                            output logic [15:0] data, output logic err, output logic [9:0] raddr);
        int n;
        n = 0;
        while (req_ready[d] !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        req_addr[d]  = addr;
        req_valid[d] = 1'b1;
        rsp_ready[d] = (bp == 0);
        @(negedge clk);
        req_valid[d] = 1'b0;
        lat = 0;
        en_pulses = 0;
        en_addr_ok = 1'b1;
        while (rsp_valid[d] !== 1'b1 && lat < 20) begin
            if (rom_en[d] === 1'b1) begin
                en_pulses++;
                if (rom_addr[d] !== addr) en_addr_ok = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        data  = rsp_data[d];
        err   = rsp_err[d];
        raddr = rsp_addr[d];
        if (rsp_valid[d] === 1'b1 && mem[addr][20] && exp_cnt[d] < cnt_max(d))
            exp_cnt[d]++;
        held_ok = 1'b1;
        for (int i = 0; i < bp; i++) begin
            req_valid[d] = 1'b1;
            req_addr[d]  = ~addr;
            @(negedge clk);
            if (rsp_valid[d] !== 1'b1 || req_ready[d] !== 1'b0 || rom_en[d] !== 1'b0 ||
                rsp_data[d] !== data || rsp_err[d] !== err || rsp_addr[d] !== raddr)
                held_ok = 1'b0;
        end
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        done_ok = (rsp_valid[d] === 1'b0 && req_ready[d] === 1'b1);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (req_ready[d] !== 1'b1 || rom_en[d] !== 1'b0 || rom_addr[d] !== 10'd0 ||
                rsp_valid[d] !== 1'b0 || rsp_data[d] !== 16'd0 || rsp_err[d] !== 1'b0 ||
                rsp_addr[d] !== 10'd0 || get_cnt(d) != 0) begin
                failures++;
                $display("FAIL reset_values dut%0d: rdy=%b en=%b raddr=%h vld=%b data=%h err=%b addr=%h cnt=%0d, required 1 0 000 0 0000 0 000 0",
                         d, req_ready[d], rom_en[d], rom_addr[d], rsp_valid[d], rsp_data[d],
                         rsp_err[d], rsp_addr[d], get_cnt(d));
            end
`ifdef ROM_ECC_ERR_LOG_EN
            checks++;
            if (le_addr[d] !== 10'd0 || le_vld[d] !== 1'b0) begin
                failures++;
                $display("FAIL reset_log dut%0d: addr=%h vld=%b, required 000 0", d, le_addr[d], le_vld[d]);
            end
`endif
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_clean_read();
        int lat, enp;
        bit eok, hok, dok;
        logic [15:0] data;
        logic err;
        logic [9:0] ra;
        mem[5] = {1'b0, 4'h0, 16'hA5A5};
        run_read(0, 10'h005, 0, lat, enp, eok, hok, dok, data, err, ra);
        checks++;
        if (lat != 2 || enp != 1 || !eok) begin
            failures++;
            $display("FAIL clean_timing: lat=%0d en_pulses=%0d en_addr_ok=%0d, required 2 1 1", lat, enp, eok);
        end
        checks++;
        if (data !== 16'hA5A5 || err !== 1'b0 || ra !== 10'h005 || !dok) begin
            failures++;
            $display("FAIL clean_rsp: data=%h err=%b addr=%h done=%0d, required a5a5 0 005 1", data, err, ra, dok);
        end
        checks++;
        if (get_cnt(0) != exp_cnt[0] || rom_addr[0] !== 10'h005) begin
            failures++;
            $display("FAIL clean_cnt_hold: cnt=%0d rom_addr=%h, required %0d 005", get_cnt(0), rom_addr[0], exp_cnt[0]);
        end
        checks++;
        if (dec_cw[0] !== rom_data[0]) begin
            failures++;
            $display("FAIL dec_passthrough: got=%h required=%h", dec_cw[0], rom_data[0]);
        end
    endtask

    task automatic test_corrected_read();
        int lat, enp;
        bit eok, hok, dok;
        logic [15:0] data;
        logic err;
        logic [9:0] ra;
        mem[10'h2C3] = {1'b1, 4'h6, 16'h1234};
        run_read(0, 10'h2C3, 0, lat, enp, eok, hok, dok, data, err, ra);
        checks++;
        if (data !== 16'h1234 || err !== 1'b1 || ra !== 10'h2C3 || lat != 2) begin
            failures++;
            $display("FAIL corrected_rsp: data=%h err=%b addr=%h lat=%0d, required 1234 1 2c3 2", data, err, ra, lat);
        end
        checks++;
        if (get_cnt(0) != 1) begin
            failures++;
            $display("FAIL corrected_cnt: cnt=%0d required 1", get_cnt(0));
        end
`ifdef ROM_ECC_ERR_LOG_EN
        checks++;
        if (le_addr[0] !== 10'h2C3 || le_vld[0] !== 1'b1) begin
            failures++;
            $display("FAIL corrected_log: addr=%h vld=%b, required 2c3 1", le_addr[0], le_vld[0]);
        end
`endif
    endtask

    task automatic test_backpressure();
        int lat, enp;
        bit eok, hok, dok;
        logic [15:0] data;
        logic err;
        logic [9:0] ra, a;
        a = 10'($urandom);
        mem[a] = 21'($urandom);
        run_read(0, a, 5, lat, enp, eok, hok, dok, data, err, ra);
        checks++;
        if (!hok || !dok || data !== mem[a][15:0] || err !== mem[a][20] || ra !== a) begin
            failures++;
            $display("FAIL backpressure: held=%0d done=%0d data=%h err=%b addr=%h, required 1 1 %h %b %h",
                     hok, dok, data, err, ra, mem[a][15:0], mem[a][20], a);
        end
        a = a + 10'd1;
        mem[a] = 21'($urandom);
        run_read(0, a, 0, lat, enp, eok, hok, dok, data, err, ra);
        checks++;
        if (lat != 2 || data !== mem[a][15:0] || ra !== a) begin
            failures++;
            $display("FAIL after_backpressure: lat=%0d data=%h addr=%h, required 2 %h %h", lat, data, ra, mem[a][15:0], a);
        end
    endtask

    task automatic test_latency();
        int lat, enp;
        bit eok, hok, dok;
        logic [15:0] data;
        logic err;
        logic [9:0] ra, a;
        a = 10'($urandom);
        mem[a] = 21'($urandom);
        run_read(1, a, 0, lat, enp, eok, hok, dok, data, err, ra);
        checks++;
        if (lat != 4 || enp != 1 || !eok || data !== mem[a][15:0] || err !== mem[a][20] || ra !== a) begin
            failures++;
            $display("FAIL latency_rdlat3: lat=%0d en_pulses=%0d data=%h err=%b addr=%h, required 4 1 %h %b %h",
                     lat, enp, data, err, ra, mem[a][15:0], mem[a][20], a);
        end
    endtask

    task automatic test_counter();
        int lat, enp;
        bit eok, hok, dok;
        logic [15:0] data;
        logic err;
        logic [9:0] ra, a;
        // clear alone
        @(negedge clk);
        clr[1] = 1'b1;
        @(negedge clk);
        clr[1] = 1'b0;
        exp_cnt[1] = 0;
        checks++;
        if (get_cnt(1) != 0) begin
            failures++;
            $display("FAIL cnt_clear: cnt=%0d required 0", get_cnt(1));
        end
        for (int i = 0; i < 17; i++) begin
            a = 10'(100 + i);
            mem[a] = {1'b1, 20'($urandom)};
            run_read(1, a, 0, lat, enp, eok, hok, dok, data, err, ra);
            checks++;
            if (get_cnt(1) != exp_cnt[1] || err !== 1'b1) begin
                failures++;
                $display("FAIL cnt_step%0d: cnt=%0d err=%b, required %0d 1", i, get_cnt(1), err, exp_cnt[1]);
            end
        end
        checks++;
        if (get_cnt(1) != 15) begin
            failures++;
            $display("FAIL cnt_saturate: cnt=%0d required 15", get_cnt(1));
        end
        // clear on the same edge as an error capture, both instances
        for (int d = 0; d < 2; d++) begin
            a = 10'(300 + d);
            mem[a] = {1'b1, 20'($urandom)};
            while (req_ready[d] !== 1'b1) @(negedge clk);
            req_addr[d] = a;
            req_valid[d] = 1'b1;
            rsp_ready[d] = 1'b1;
            @(negedge clk);
            req_valid[d] = 1'b0;
            repeat (lat_of(d)) @(negedge clk);
            clr[d] = 1'b1;
            @(negedge clk);
            clr[d] = 1'b0;
            exp_cnt[d] = 1;
            checks++;
            if (get_cnt(d) != 1 || rsp_valid[d] !== 1'b1) begin
                failures++;
                $display("FAIL cnt_clr_with_err dut%0d: cnt=%0d vld=%b, required 1 1", d, get_cnt(d), rsp_valid[d]);
            end
`ifdef ROM_ECC_ERR_LOG_EN
            checks++;
            if (le_addr[d] !== a || le_vld[d] !== 1'b1) begin
                failures++;
                $display("FAIL log_clr_with_err dut%0d: addr=%h vld=%b, required %h 1", d, le_addr[d], le_vld[d], a);
            end
`endif
            @(negedge clk);
        end
`ifdef ROM_ECC_ERR_LOG_EN
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        exp_cnt[0] = 0;
        checks++;
        if (le_vld[0] !== 1'b0 || get_cnt(0) != 0) begin
            failures++;
            $display("FAIL log_clear: vld=%b cnt=%0d, required 0 0", le_vld[0], get_cnt(0));
        end
`endif
    endtask

    task automatic test_random();
        int lat, enp, d, bp;
        bit eok, hok, dok;
        logic [15:0] data;
        logic err;
        logic [9:0] ra, a;
        for (int i = 0; i < 24; i++) begin
            d  = i % 2;
            bp = $urandom_range(0, 3);
            a  = 10'($urandom);
            mem[a] = 21'($urandom);
            run_read(d, a, bp, lat, enp, eok, hok, dok, data, err, ra);
            checks++;
            if (lat != lat_of(d) + 1 || enp != 1 || !eok || !hok || !dok ||
                data !== mem[a][15:0] || err !== mem[a][20] || ra !== a || get_cnt(d) != exp_cnt[d]) begin
                failures++;
                $display("FAIL random%0d dut%0d: lat=%0d en=%0d eok=%0d held=%0d done=%0d data=%h err=%b addr=%h cnt=%0d, required lat=%0d en=1 1 1 1 %h %b %h cnt=%0d",
                         i, d, lat, enp, eok, hok, dok, data, err, ra, get_cnt(d),
                         lat_of(d) + 1, mem[a][15:0], mem[a][20], a, exp_cnt[d]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc_idx [$];
        logic [9:0] a;
        for (int d = 0; d < 2; d++) begin
            acc_idx.delete();
            rsp_ready[d] = 1'b1;
            req_valid[d] = 1'b1;
            for (int i = 0; i < 4 * (lat_of(d) + 3) + 1; i++) begin
                a = 10'($urandom);
                req_addr[d] = a;
                if (req_ready[d] === 1'b1) begin
                    acc_idx.push_back(i);
                    if (mem[a][20] && exp_cnt[d] < cnt_max(d)) exp_cnt[d]++;
                end
                @(negedge clk);
            end
            req_valid[d] = 1'b0;
            repeat (lat_of(d) + 4) @(negedge clk);
            checks++;
            if (acc_idx.size() < 4) begin
                failures++;
                $display("FAIL b2b_count dut%0d: accepts=%0d required >=4", d, acc_idx.size());
            end
            for (int k = 1; k < acc_idx.size(); k++) begin
                checks++;
                if (acc_idx[k] - acc_idx[k-1] != lat_of(d) + 3) begin
                    failures++;
                    $display("FAIL b2b_gap dut%0d: gap=%0d required %0d", d, acc_idx[k] - acc_idx[k-1], lat_of(d) + 3);
                end
            end
            checks++;
            if (get_cnt(d) != exp_cnt[d] || rsp_valid[d] !== 1'b0) begin
                failures++;
                $display("FAIL b2b_cnt dut%0d: cnt=%0d vld=%b, required %0d 0", d, get_cnt(d), rsp_valid[d], exp_cnt[d]);
            end
        end
    endtask

    task automatic test_reset_in_wait();
        int lat, enp;
        bit eok, hok, dok, saw;
        logic [15:0] data;
        logic err;
        logic [9:0] ra, a;
        a = 10'($urandom);
        mem[a] = {1'b1, 20'($urandom)};
        while (req_ready[1] !== 1'b1) @(negedge clk);
        req_addr[1] = a;
        req_valid[1] = 1'b1;
        rsp_ready[1] = 1'b1;
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        checks++;
        if (req_ready[1] !== 1'b1 || rom_en[1] !== 1'b0 || rom_addr[1] !== 10'd0 || rsp_valid[1] !== 1'b0 ||
            rsp_data[1] !== 16'd0 || rsp_err[1] !== 1'b0 || rsp_addr[1] !== 10'd0 || get_cnt(1) != 0) begin
            failures++;
            $display("FAIL reset_in_wait: rdy=%b en=%b raddr=%h vld=%b data=%h err=%b addr=%h cnt=%0d, required 1 0 000 0 0000 0 000 0",
                     req_ready[1], rom_en[1], rom_addr[1], rsp_valid[1], rsp_data[1], rsp_err[1], rsp_addr[1], get_cnt(1));
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid[1] !== 1'b0) saw = 1'b1;
        end
        checks++;
        if (saw) begin
            failures++;
            $display("FAIL reset_drop_rsp: stray rsp_valid=1 seen, required none");
        end
        a = a ^ 10'h155;
        mem[a] = 21'($urandom);
        run_read(1, a, 0, lat, enp, eok, hok, dok, data, err, ra);
        checks++;
        if (lat != 4 || data !== mem[a][15:0] || err !== mem[a][20] || ra !== a || get_cnt(1) != exp_cnt[1]) begin
            failures++;
            $display("FAIL reset_fresh_read: lat=%0d data=%h err=%b addr=%h cnt=%0d, required 4 %h %b %h %0d",
                     lat, data, err, ra, get_cnt(1), mem[a][15:0], mem[a][20], a, exp_cnt[1]);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 21'($urandom);
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_addr[d]  = '0;
            rsp_ready[d] = 1'b1;
            clr[d]       = 1'b0;
            exp_cnt[d]   = 0;
        end
        test_reset();
        test_clean_read();
        test_corrected_read();
        test_backpressure();
        test_latency();
        test_counter();
        test_random();
        test_back_to_back();
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
